prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream boot loader for the C0 CPU: writer end of the instruction-fetch path. The CPU and
//  the instruction memory are the readers. Assembles 21-bit instruction words from a byte stream,
//  writes them into the program RAM and verifies a trailing XOR checksum. Drives BOOT, which
//  holds the CPU in reset and steers the program-memory address mux while loading.
// PARAMETERS
//  AW         8   program RAM address width (instruction pointer width)
//  IW         21  instruction width; fixed at 21 (3 bytes, byte2 carries INS[20:16])
//  LOAD_BASE  0   first RAM address written
// PORTS
//  CLK        in   1   single system clock; all state updates on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  START      in   1   1-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  DIN        in   8   stream byte
//  DIN_VALID  in   1   DIN holds a valid byte
//  DIN_READY  out  1   loader accepts DIN this cycle; transfer = DIN_VALID & DIN_READY at edge
//  WE         out  1   program RAM write strobe, 1 cycle per instruction
//  WADDR      out  AW  program RAM write address
//  WDATA      out  IW  program RAM write data
//  BOOT       out  1   1 = CPU held in reset, memory address from loader side
//  BUSY       out  1   load in progress
//  DONE       out  1   last load completed with good checksum
//  ERROR      out  1   last load aborted (reserved bits set or checksum mismatch)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; BOOT=1; DIN_READY=WE=BUSY=DONE=ERROR=0;
//   WADDR=LOAD_BASE; WDATA=0; count, checksum and byte registers cleared. RAM contents untouched.
//  Stream format: CNT, then CNT x {B0=INS[7:0], B1=INS[15:8], B2={3'b000,INS[20:16]}}, then CSUM.
//   CNT=0 means no instructions. CSUM is chosen so that the XOR of all stream bytes incl. CSUM = 8'h00.
//  States / transitions:
//   IDLE : READY=0. START -> GETCNT (clear csum, WADDR=LOAD_BASE, DONE=ERROR=0, BUSY=1).
//   GETCNT: READY=1. On xfer: store CNT; CNT==0 -> GETCSUM, else -> GETB0.
//   GETB0/GETB1: READY=1. On xfer: latch byte, advance.
//   GETB2: READY=1. On xfer: DIN[7:5]!=0 -> ERR (no write); else -> WRITE.
//   WRITE: READY=0; WE=1 for exactly this cycle with WDATA={B2[4:0],B1,B0} at current WADDR.
//    Next edge: WADDR<=WADDR+1 (mod 2^AW, wraps silently); remaining-1; remaining==0 -> GETCSUM,
//    else -> GETB0.
//   GETCSUM: READY=1. On xfer: running XOR ^ DIN == 0 -> DONE, else -> ERR.
//   DONE : BOOT=0, DONE=1, BUSY=0. START -> GETCNT (BOOT back to 1 on the same edge).
//   ERR  : BOOT=1, ERROR=1, BUSY=0. START -> GETCNT.
//  Running XOR updated on every accepted byte, CNT and CSUM included.
//  Latency: B2 accepted at edge k -> WE high in cycle k..k+1 (registered); one byte max per cycle.
//  DIN_VALID low in a GET state: hold state, no timeout. DIN ignored when READY=0.
//  START during a load (GET*/WRITE) ignored. START and xfer same cycle in IDLE: start only.
//  Writes already issued before ERR are not rolled back; BOOT keeps the CPU held.
//  reset_n low mid-load: immediate abort to reset values, no further WE.
//  All outputs registered; no combinational path from DIN/DIN_VALID/START to any output.
// TESTING
//  1 Reset, START, stream 01 FF C0 05 3B (JMP #0) -> one WE, WADDR=00, WDATA=05C0FF; DONE=1,
//    BOOT=0, ERROR=0.
//  2 START, stream 02 05 00 0C 20 00 18 33 -> WE @00 data 0C0005, WE @01 data 180020; DONE=1.
//  3 As 2 but CSUM=34 -> both writes occur, then ERROR=1, BOOT=1, DONE=0; START recovers.
//  4 START, stream 01 FF C0 25 -> ERROR=1 right after B2, no WE; BOOT=1.
//  5 START, stream 00 00 -> DONE=1, no WE; then a random DIN_VALID gaps/backpressure rerun of 2
//    -> identical writes.
//  6 Assert reset_n low after B1 of test 2 -> no WE, BOOT=1, state IDLE; a fresh load then passes.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Byte-stream boot loader for the C0 CPU. It builds 21-bit instruction words
//   from a byte stream, writes them into program RAM, and then checks the
//   trailing XOR checksum. While a load is running, or after a load has failed,
//   BOOT holds the CPU in reset and selects the loader side of the
//   program-memory address mux.
//
//   Stream: CNT, CNT x {B0=INS[7:0], B1=INS[15:8], B2={3'b000,INS[20:16]}}, CSUM
//           The XOR of every byte in the stream, CSUM included, must be 8'h00.
//
// Ports
//   CLK        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   START      in   one-cycle pulse that starts a load (idle/done/error only)
//   DIN        in   stream byte
//   DIN_VALID  in   DIN carries a valid byte
//   DIN_READY  out  loader takes DIN at the next edge when DIN_VALID is high
//   WE         out  program RAM write strobe, one cycle per instruction
//   WADDR      out  program RAM write address
//   WDATA      out  program RAM write data
//   BOOT       out  1 = CPU held in reset, memory addressed by the loader
//   BUSY       out  load in progress
//   DONE       out  last load finished with a good checksum
//   ERROR      out  last load aborted (reserved bits or bad checksum)
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int AW        = 8,
  parameter int IW        = 21,
  parameter int LOAD_BASE = 0
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          START,
  input  logic [7:0]    DIN,
  input  logic          DIN_VALID,
  output logic          DIN_READY,
  output logic          WE,
  output logic [AW-1:0] WADDR,
  output logic [IW-1:0] WDATA,
  output logic          BOOT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERROR
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(LOAD_BASE);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GETCNT,
    ST_GETB0,
    ST_GETB1,
    ST_GETB2,
    ST_WRITE,
    ST_GETCSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;      // instructions still to be written
  logic [7:0]    csum_q, csum_d;    // running XOR of accepted bytes
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic          boot_q, boot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          xfer;
  logic [7:0]    csum_in;

  // A transfer happens only when DIN_READY is already high. Because
  // DIN_READY is a flop, DIN has no combinational path to any output.
  assign xfer    = DIN_VALID & ready_q;
  assign csum_in = csum_q ^ DIN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (START) begin
          state_d = ST_GETCNT;
          csum_d  = 8'h00;
          cnt_d   = 8'h00;
          waddr_d = BASE_ADDR;
        end
      end
      ST_GETCNT: begin
        if (xfer) begin
          csum_d  = csum_in;
          cnt_d   = DIN;
          state_d = (DIN == 8'h00) ? ST_GETCSUM : ST_GETB0;
        end
      end
      ST_GETB0: begin
        if (xfer) begin
          csum_d  = csum_in;
          b0_d    = DIN;
          state_d = ST_GETB1;
        end
      end
      ST_GETB1: begin
        if (xfer) begin
          csum_d  = csum_in;
          b1_d    = DIN;
          state_d = ST_GETB2;
        end
      end
      ST_GETB2: begin
        if (xfer) begin
          csum_d = csum_in;
          if (DIN[7:5] != 3'b000) begin
            state_d = ST_ERR;
          end else begin
            wdata_d = IW'({DIN[4:0], b1_q, b0_q});
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // The strobe is high during this cycle. The address moves on at the
        // edge that ends the strobe, so WADDR stays stable while WE is high.
        waddr_d = waddr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? ST_GETCSUM : ST_GETB0;
      end
      ST_GETCSUM: begin
        if (xfer) begin
          csum_d  = csum_in;
          state_d = (csum_in == 8'h00) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state, so each registered output
    // lines up with the state that it describes.
    ready_d = (state_d == ST_GETCNT) || (state_d == ST_GETB0) ||
              (state_d == ST_GETB1)  || (state_d == ST_GETB2) ||
              (state_d == ST_GETCSUM);
    we_d    = (state_d == ST_WRITE);
    busy_d  = ready_d || (state_d == ST_WRITE);
    boot_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERR);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'h00;
      csum_q  <= 8'h00;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      boot_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      boot_q  <= boot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign DIN_READY = ready_q;
  assign WE        = we_q;
  assign WADDR     = waddr_q;
  assign WDATA     = wdata_q;
  assign BOOT      = boot_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader. It runs directed streams, random
//   streams, and a maximum-count stream. A byte-list reference model produces
//   the expected RAM writes and the final status of each load.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int LOAD_BASE = 0;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY, WE, BOOT, BUSY, DONE, ERROR;
  logic [7:0]  WADDR;
  logic [20:0] WDATA;

  prog_loader #(.AW(8), .IW(21), .LOAD_BASE(LOAD_BASE)) dut (
    .CLK(CLK), .reset_n(reset_n), .START(START), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .BOOT(BOOT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  stream_q[$];
  logic [7:0]  got_addr[$];
  logic [20:0] got_data[$];
  logic [7:0]  exp_addr[$];
  logic [20:0] exp_data[$];
  bit          exp_done;

  // Record every write strobe away from the active edge.
  always @(negedge CLK) begin
    if (WE) begin
      got_addr.push_back(WADDR);
      got_data.push_back(WDATA);
    end
  end

  // Reference model: walk the byte list using the stream rules.
  task automatic model();
    int cnt, idx, b0, b1, b2;
    int x;
    bit err;
    exp_addr.delete();
    exp_data.delete();
    cnt = int'(stream_q[0]);
    x   = cnt;
    idx = 1;
    err = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      b0 = int'(stream_q[idx]);
      b1 = int'(stream_q[idx+1]);
      b2 = int'(stream_q[idx+2]);
      idx += 3;
      x = x ^ b0 ^ b1 ^ b2;
      if (b2 >= 32) begin
        err = 1'b1;
        break;
      end
      exp_addr.push_back(8'((LOAD_BASE + i) % 256));
      exp_data.push_back(21'((b2 % 32) * 65536 + b1 * 256 + b0));
    end
    if (!err) begin
      x = x ^ int'(stream_q[idx]);
      err = (x != 0);
    end
    exp_done = !err;
  endtask

  task automatic do_start();
    @(negedge CLK);
    START = 1'b1;
    DIN_VALID = 1'b1;   // same cycle as START: this byte must be ignored
    DIN = 8'($urandom);
    @(negedge CLK);
    START = 1'b0;
    DIN_VALID = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  // Send stream_q. When gaps is set, insert random idle cycles, and
  // sometimes a START pulse, which the loader ignores while a load is running.
  task automatic send_stream(input bit gaps);
    bit got;
    int g;
    for (int i = 0; i < stream_q.size(); i++) begin
      got = 1'b0;
      if (gaps) begin
        g = int'($urandom_range(0, 3));
        for (int k = 0; k < g; k++) begin
          @(negedge CLK);
          DIN_VALID = 1'b0;
          DIN = 8'($urandom);
          START = ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge CLK);
      START = 1'b0;
      DIN = stream_q[i];
      DIN_VALID = 1'b1;
      for (int w = 0; w < 20 && !got; w++) begin
        if (DIN_READY) begin
          @(posedge CLK);
          got = 1'b1;
        end else begin
          @(negedge CLK);
        end
      end
      if (!got) begin
        n_total++;
        $display("FAIL xfer_timeout byte %0d: DIN_READY=%0b, required 1", i, DIN_READY);
        DIN_VALID = 1'b0;
        return;
      end
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    START = 1'b0;
  endtask

  task automatic set_stream(input logic [7:0] b[]);
    stream_q.delete();
    foreach (b[i]) stream_q.push_back(b[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_total++;
    if ({DIN_READY, WE, BOOT, BUSY, DONE, ERROR} !== 6'b001000)
      $display("FAIL reset_flags: got %b required 001000", {DIN_READY, WE, BOOT, BUSY, DONE, ERROR});
    else n_pass++;
    n_total++;
    if (WADDR !== 8'h00 || WDATA !== 21'h0)
      $display("FAIL reset_addr_data: got %h/%h required 00/000000", WADDR, WDATA);
    else n_pass++;
    reset_n = 1'b1;
    DIN_VALID = 1'b1;
    DIN = 8'h01;
    repeat (3) @(negedge CLK);
    DIN_VALID = 1'b0;
    n_total++;
    if (DIN_READY !== 1'b0 || got_addr.size() != 0 || BUSY !== 1'b0)
      $display("FAIL idle_ignores_din: ready=%0b writes=%0d busy=%0b required 0/0/0", DIN_READY, got_addr.size(), BUSY);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_start();
    n_total++;
    if ({BUSY, BOOT, DIN_READY, DONE} !== 4'b1110)
      $display("FAIL start_flags: busy/boot/ready/done=%b required 1110", {BUSY, BOOT, DIN_READY, DONE});
    else n_pass++;
    set_stream('{8'h01, 8'hFF, 8'hC0, 8'h05, 8'h3B});
    send_stream(1'b0);
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 1 || got_addr[0] !== 8'h00 || got_data[0] !== 21'h05C0FF)
      $display("FAIL single_write: n=%0d addr=%h data=%h required 1/00/05C0FF", got_addr.size(),
               got_addr.size() > 0 ? got_addr[0] : 8'hxx, got_data.size() > 0 ? got_data[0] : 21'hx);
    else n_pass++;
    n_total++;
    if ({DONE, BOOT, ERROR, BUSY} !== 4'b1000)
      $display("FAIL single_status: done/boot/err/busy=%b required 1000", {DONE, BOOT, ERROR, BUSY});
    else n_pass++;
    $display("test_single: %0d write(s)", got_addr.size());
  endtask

  task automatic test_two(input bit bad_csum, input bit gaps, input string name);
    do_start();
    set_stream('{8'h02, 8'h05, 8'h00, 8'h0C, 8'h20, 8'h00, 8'h18, bad_csum ? 8'h34 : 8'h33});
    exp_addr = '{8'h00, 8'h01};
    exp_data = '{21'h0C0005, 21'h180020};
    send_stream(gaps);
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 2)
      $display("FAIL %s_count: got %0d writes required 2", name, got_addr.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
      n_total++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL %s_write%0d: got %h/%h required %h/%h", name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_total++;
    if ({DONE, ERROR, BOOT, BUSY} !== (bad_csum ? 4'b0110 : 4'b1000))
      $display("FAIL %s_status: done/err/boot/busy=%b required %b", name, {DONE, ERROR, BOOT, BUSY},
               bad_csum ? 4'b0110 : 4'b1000);
    else n_pass++;
    $display("%s: %0d write(s) done=%0b error=%0b", name, got_addr.size(), DONE, ERROR);
  endtask

  task automatic test_reserved();
    do_start();
    set_stream('{8'h01, 8'hFF, 8'hC0, 8'h25});
    send_stream(1'b0);
    n_total++;
    if (ERROR !== 1'b1 || BOOT !== 1'b1 || DONE !== 1'b0)
      $display("FAIL reserved_status: err/boot/done=%b required 110", {ERROR, BOOT, DONE});
    else n_pass++;
    repeat (2) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 0)
      $display("FAIL reserved_nowrite: got %0d writes required 0", got_addr.size());
    else n_pass++;
    $display("test_reserved: error=%0b writes=%0d", ERROR, got_addr.size());
  endtask

  task automatic test_empty();
    do_start();
    set_stream('{8'h00, 8'h00});
    send_stream(1'b0);
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 0 || {DONE, ERROR, BOOT} !== 3'b100)
      $display("FAIL empty_load: writes=%0d done/err/boot=%b required 0/100", got_addr.size(), {DONE, ERROR, BOOT});
    else n_pass++;
    $display("test_empty: done=%0b", DONE);
  endtask

  task automatic test_reset_midload();
    do_start();
    set_stream('{8'h02, 8'h05, 8'h00});
    send_stream(1'b0);
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({WE, BOOT, BUSY, DIN_READY, DONE, ERROR} !== 6'b010000 || WADDR !== 8'h00)
      $display("FAIL midload_reset: we/boot/busy/ready/done/err=%b waddr=%h required 010000/00",
               {WE, BOOT, BUSY, DIN_READY, DONE, ERROR}, WADDR);
    else n_pass++;
    DIN_VALID = 1'b1;
    DIN = 8'h0C;
    repeat (3) @(negedge CLK);
    DIN_VALID = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 0 || BUSY !== 1'b0)
      $display("FAIL midload_nowrite: writes=%0d busy=%0b required 0/0", got_addr.size(), BUSY);
    else n_pass++;
    $display("test_reset_midload: writes=%0d", got_addr.size());
  endtask

  task automatic test_random(input int iters);
    int cnt, bad_at, x, b0, b1, b2, csum;
    for (int it = 0; it < iters; it++) begin
      stream_q.delete();
      cnt = int'($urandom_range(0, 6));
      stream_q.push_back(8'(cnt));
      x = cnt;
      bad_at = (cnt > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
      for (int i = 0; i < cnt; i++) begin
        b0 = int'($urandom_range(0, 255));
        b1 = int'($urandom_range(0, 255));
        b2 = (i == bad_at) ? int'($urandom_range(32, 255)) : int'($urandom_range(0, 31));
        stream_q.push_back(8'(b0));
        stream_q.push_back(8'(b1));
        stream_q.push_back(8'(b2));
        x = x ^ b0 ^ b1 ^ b2;
        if (i == bad_at) break;
      end
      if (bad_at < 0) begin
        csum = x;
        if ($urandom_range(0, 4) == 0) csum = csum ^ int'($urandom_range(1, 255));
        stream_q.push_back(8'(csum));
      end
      model();
      do_start();
      send_stream(1'b1);
      repeat (3) @(negedge CLK);
      n_total++;
      if (got_addr.size() != exp_addr.size())
        $display("FAIL rand%0d_count: got %0d writes required %0d", it, got_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_total++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
          $display("FAIL rand%0d_write%0d: got %h/%h required %h/%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_total++;
      if ({DONE, ERROR, BOOT, BUSY} !== (exp_done ? 4'b1000 : 4'b0110))
        $display("FAIL rand%0d_status: done/err/boot/busy=%b required %b", it, {DONE, ERROR, BOOT, BUSY},
                 exp_done ? 4'b1000 : 4'b0110);
      else n_pass++;
      $display("rand%0d: cnt=%0d writes=%0d done=%0b", it, cnt, got_addr.size(), DONE);
    end
  endtask

  task automatic test_max_count();
    int x;
    stream_q.delete();
    stream_q.push_back(8'hFF);
    x = 255;
    for (int i = 0; i < 255 * 3; i++) begin
      stream_q.push_back((i % 3 == 2) ? 8'($urandom_range(0, 31)) : 8'($urandom));
      x = x ^ int'(stream_q[i+1]);
    end
    stream_q.push_back(8'(x));
    model();
    do_start();
    send_stream(1'b0);
    repeat (3) @(negedge CLK);
    n_total++;
    if (got_addr.size() != 255 || got_addr[got_addr.size()-1] !== 8'hFE)
      $display("FAIL max_count: writes=%0d required 255 ending at FE", got_addr.size());
    else n_pass++;
    n_total++;
    if (got_data != exp_data || DONE !== 1'b1)
      $display("FAIL max_data: data queue differs or done=%0b, required model data and done=1", DONE);
    else n_pass++;
    $display("test_max_count: writes=%0d done=%0b", got_addr.size(), DONE);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two(1'b0, 1'b0, "two_good");
    test_two(1'b1, 1'b0, "two_badcsum");
    test_two(1'b0, 1'b0, "recover");
    test_reserved();
    test_empty();
    test_two(1'b0, 1'b1, "two_gaps");
    test_reset_midload();
    test_two(1'b0, 1'b0, "after_reset");
    test_random(40);
    test_max_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
